move_sequencer: RTL and testbench

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/puzzle_pkg.sv | 27 ++
 rtl/move_legality.sv | 40 ++++
 rtl/move_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_move_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puzzle_pkg.sv
// Shared constants for the 8-puzzle move sequencer: register-file map,
// direction encoding and the sequencer state enumeration.
package puzzle_pkg;

  localparam int BOARD_BASE = 0;
  localparam int IDEAL_BASE = 9;
  localparam int SLIDE_ADDR = 27;
  localparam int SPACE_ADDR = 29;

  // Direction in which the blank tile travels.
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_IDLE,
    ST_CALC,
    ST_MOVE,
    ST_CLEAR,
    ST_SPACE,
    ST_COUNT,
    ST_CHECK
  } state_t;

endpackage

// File: rtl/move_legality.sv
// Combinational target/legality calculation for moving the blank tile
// on a 3x3 board stored row-major in cells 0..8.
module move_legality
  import puzzle_pkg::*;
(
  input  logic [3:0] i_s,
  input  logic [1:0] i_dir,
  output logic [3:0] o_t,
  output logic       o_legal
);

  logic [3:0] w_col;

  assign w_col = i_s % 4'd3;

  // Edge columns and rows forbid moves that would leave the board.
  always_comb begin
    o_t     = i_s;
    o_legal = 1'b0;
    case (i_dir)
      DIR_UP: begin
        o_t     = i_s - 4'd3;
        o_legal = (i_s >= 4'd3);
      end
      DIR_DOWN: begin
        o_t     = i_s + 4'd3;
        o_legal = (i_s <= 4'd5);
      end
      DIR_LEFT: begin
        o_t     = i_s - 4'd1;
        o_legal = (w_col != 4'd0);
      end
      DIR_RIGHT: begin
        o_t     = i_s + 4'd1;
        o_legal = (w_col != 4'd2);
      end
    endcase
  end

endmodule

// File: rtl/move_sequencer.sv
// 8-puzzle move sequencer: finds the blank, executes slide commands through
// an external register file and reports whether the board matches the goal.
module move_sequencer
  import puzzle_pkg::*;
#(
  parameter int DW = 17,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_dir,
  output logic          cmd_ready,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic          solved,
  output logic          fault,
  output logic [AW-1:0] rf_src0,
  output logic [AW-1:0] rf_src1,
  output logic [AW-1:0] rf_dst,
  output logic          rf_we,
  output logic [DW-1:0] rf_wdata,
  input  logic [DW-1:0] rf_data0,
  input  logic [DW-1:0] rf_data1
);

  state_t     r_state;
  logic [3:0] r_idx;
  logic [1:0] r_dir;
  logic [3:0] r_s;
  logic [3:0] r_t;
  logic       r_fromMove;
  logic       r_match;
  logic       r_done;
  logic       r_illegal;
  logic       r_solved;
  logic       r_fault;

  logic [3:0]    w_t;
  logic          w_legal;
  logic          w_ready;
  logic          w_scanHit;
  logic          w_pairMatch;
  logic          w_lastIdx;
  logic [AW-1:0] w_src0;
  logic [AW-1:0] w_src1;
  logic [AW-1:0] w_dst;
  logic          w_we;
  logic [DW-1:0] w_wdata;

  move_legality u_legality (
    .i_s    (rf_data0[3:0]),
    .i_dir  (r_dir),
    .o_t    (w_t),
    .o_legal(w_legal)
  );

  assign w_ready     = (r_state == ST_IDLE) && !r_fault;
  assign w_scanHit   = (rf_data0 == '0);
  assign w_pairMatch = (rf_data0 == rf_data1);
  assign w_lastIdx   = (r_idx == 4'd8);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_SCAN;
      r_idx      <= 4'd0;
      r_dir      <= DIR_UP;
      r_s        <= 4'd0;
      r_t        <= 4'd0;
      r_fromMove <= 1'b0;
      r_match    <= 1'b0;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
      r_solved   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_SCAN: begin
          if (w_scanHit) begin
            r_idx      <= 4'd0;
            r_match    <= 1'b1;
            r_fromMove <= 1'b0;
            r_state    <= ST_CHECK;
          end else if (w_lastIdx) begin
            r_idx   <= 4'd0;
            r_fault <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
        ST_IDLE: begin
          if (cmd_valid && w_ready) begin
            r_dir   <= cmd_dir;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_s <= rf_data0[3:0];
          r_t <= w_t;
          if (w_legal) begin
            r_state <= ST_MOVE;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_MOVE:  r_state <= ST_CLEAR;
        ST_CLEAR: r_state <= ST_SPACE;
        ST_SPACE: r_state <= ST_COUNT;
        ST_COUNT: begin
          r_idx      <= 4'd0;
          r_match    <= 1'b1;
          r_fromMove <= 1'b1;
          r_state    <= ST_CHECK;
        end
        // Only a check that closes a move reports done; the post-scan one is silent.
        ST_CHECK: begin
          if (w_lastIdx) begin
            r_solved <= r_match && w_pairMatch;
            r_done   <= r_fromMove;
            r_idx    <= 4'd0;
            r_state  <= ST_IDLE;
          end else begin
            r_match <= r_match && w_pairMatch;
            r_idx   <= r_idx + 4'd1;
          end
        end
        default: r_state <= ST_SCAN;
      endcase
    end
  end

  always_comb begin
    w_src0  = '0;
    w_src1  = '0;
    w_dst   = '0;
    w_we    = 1'b0;
    w_wdata = '0;
    case (r_state)
      ST_SCAN: begin
        w_src0 = AW'(BOARD_BASE) + AW'(r_idx);
        if (w_scanHit) begin
          w_we    = 1'b1;
          w_dst   = AW'(SPACE_ADDR);
          w_wdata = DW'(r_idx);
        end
      end
      ST_CALC: w_src0 = AW'(SPACE_ADDR);
      ST_MOVE: begin
        w_src0  = AW'(BOARD_BASE) + AW'(r_t);
        w_dst   = AW'(BOARD_BASE) + AW'(r_s);
        w_we    = 1'b1;
        w_wdata = rf_data0;
      end
      ST_CLEAR: begin
        w_dst = AW'(BOARD_BASE) + AW'(r_t);
        w_we  = 1'b1;
      end
      ST_SPACE: begin
        w_dst   = AW'(SPACE_ADDR);
        w_we    = 1'b1;
        w_wdata = DW'(r_t);
      end
      ST_COUNT: begin
        w_src0  = AW'(SLIDE_ADDR);
        w_dst   = AW'(SLIDE_ADDR);
        w_we    = 1'b1;
        w_wdata = rf_data0 + DW'(1);
      end
      ST_CHECK: begin
        w_src0 = AW'(BOARD_BASE) + AW'(r_idx);
        w_src1 = AW'(IDEAL_BASE) + AW'(r_idx);
      end
      default: ;
    endcase
  end

  // Gating with rst_n drops writes and handshakes the moment reset asserts,
  // even before the synchronous reset edge arrives.
  assign rf_src0   = w_src0;
  assign rf_src1   = w_src1;
  assign rf_dst    = w_dst;
  assign rf_we     = w_we && rst_n;
  assign rf_wdata  = w_wdata;
  assign cmd_ready = w_ready && rst_n;
  assign busy      = (r_state != ST_IDLE) && rst_n;
  assign done      = r_done;
  assign illegal   = r_illegal;
  assign solved    = r_solved;
  assign fault     = r_fault;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: table of directed moves, randomized
// moves against a row/column board model, and reset/fault corner cases.
module tb_move_sequencer;

  localparam int DW = 17;
  localparam int AW = 5;
  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] RIGHT = 2'd3;

  typedef struct {
    logic [1:0] dir;
    bit         expLegal;
    int         expBlank;
    int         expSlides;
    bit         expSolved;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_dir = 2'd0;
  logic          cmd_ready, busy, done, illegal, solved, fault;
  logic [AW-1:0] rf_src0, rf_src1, rf_dst;
  logic          rf_we;
  logic [DW-1:0] rf_wdata, rf_data0, rf_data1;

  logic [DW-1:0] rf [32];
  logic [DW-1:0] rfStage [32];
  logic          tbLoad = 1'b0;
  int            weCount = 0;
  int            edgesSinceRelease = 0;
  int            lastSpaceWriteEdge = 0;

  int assertCount = 0;
  int failCount = 0;

  int  idealBoard[9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
  int  boardA[9]      = '{1, 2, 3, 4, 0, 5, 7, 8, 6};
  int  boardSolved[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
  int  mdlBoard[9];
  int  mdlBlank;
  int  mdlSlides;
  bit  mdlSolved;
  vec_t vecs[15];

  move_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_dir  (cmd_dir),
    .cmd_ready(cmd_ready),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal),
    .solved   (solved),
    .fault    (fault),
    .rf_src0  (rf_src0),
    .rf_src1  (rf_src1),
    .rf_dst   (rf_dst),
    .rf_we    (rf_we),
    .rf_wdata (rf_wdata),
    .rf_data0 (rf_data0),
    .rf_data1 (rf_data1)
  );

  always #5 clk = ~clk;

  // Register file with combinational reads; also logs write activity.
  assign rf_data0 = rf[rf_src0];
  assign rf_data1 = rf[rf_src1];

  always @(posedge clk) begin
    if (!rst_n) begin
      edgesSinceRelease  <= 0;
      lastSpaceWriteEdge <= 0;
    end else begin
      edgesSinceRelease <= edgesSinceRelease + 1;
    end
    if (rf_we === 1'b1) begin
      weCount <= weCount + 1;
      if (rst_n && rf_dst == 5'd29 && lastSpaceWriteEdge == 0)
        lastSpaceWriteEdge <= edgesSinceRelease + 1;
    end
    if (tbLoad) begin
      for (int i = 0; i < 32; i++) rf[i] <= rfStage[i];
    end else if (rf_we === 1'b1) begin
      rf[rf_dst] <= rf_wdata;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit mdlTarget(input int b, input logic [1:0] dir, output int t);
    int row;
    int col;
    bit ok;
    row = b / 3;
    col = b % 3;
    t   = b;
    ok  = 1'b0;
    case (dir)
      UP:    begin ok = (row > 0); t = b - 3; end
      DOWN:  begin ok = (row < 2); t = b + 3; end
      LEFT:  begin ok = (col > 0); t = b - 1; end
      RIGHT: begin ok = (col < 2); t = b + 1; end
    endcase
    return ok;
  endfunction

  function automatic bit mdlMatches();
    for (int i = 0; i < 9; i++)
      if (mdlBoard[i] != idealBoard[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelMove(input logic [1:0] dir, output bit legal);
    int t;
    legal = mdlTarget(mdlBlank, dir, t);
    if (legal) begin
      mdlBoard[mdlBlank] = mdlBoard[t];
      mdlBoard[t]        = 0;
      mdlBlank           = t;
      mdlSlides          = (mdlSlides + 1) % (1 << DW);
      mdlSolved          = mdlMatches();
    end
  endtask

  task automatic loadRf(input int board[9]);
    for (int i = 0; i < 32; i++) rfStage[i] = '0;
    for (int i = 0; i < 9; i++) begin
      rfStage[i]     = DW'(board[i]);
      rfStage[9 + i] = DW'(idealBoard[i]);
      mdlBoard[i]    = board[i];
    end
    rfStage[29] = DW'(15);
    mdlSlides = 0;
    mdlBlank  = -1;
    for (int i = 8; i >= 0; i--)
      if (board[i] == 0) mdlBlank = i;
    mdlSolved = (mdlBlank >= 0) ? mdlMatches() : 1'b0;
    tbLoad = 1'b1;
    @(posedge clk); #1;
    tbLoad = 1'b0;
  endtask

  task automatic holdReset(input string tag);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput($sformatf("%s rf_we", tag), 32'(rf_we), 0);
    checkOutput($sformatf("%s cmd_ready", tag), 32'(cmd_ready), 0);
    checkOutput($sformatf("%s busy", tag), 32'(busy), 0);
    checkOutput($sformatf("%s done", tag), 32'(done), 0);
    checkOutput($sformatf("%s illegal", tag), 32'(illegal), 0);
    checkOutput($sformatf("%s solved", tag), 32'(solved), 0);
    checkOutput($sformatf("%s fault", tag), 32'(fault), 0);
  endtask

  task automatic releaseAndScan(input string tag);
    int readyEdge;
    int faultEdge;
    int doneSeen;
    int weStart;
    readyEdge = 0;
    faultEdge = 0;
    doneSeen  = 0;
    weStart   = weCount;
    rst_n     = 1'b1;
    for (int k = 1; k <= 40 && readyEdge == 0; k++) begin
      @(posedge clk); #1;
      if (cmd_ready === 1'b1) readyEdge = k;
      if (fault === 1'b1 && faultEdge == 0) faultEdge = k;
      if (done === 1'b1) doneSeen++;
    end
    if (mdlBlank >= 0) begin
      checkOutput($sformatf("%s blank write edge", tag), lastSpaceWriteEdge, mdlBlank + 1);
      checkOutput($sformatf("%s ready edge", tag), readyEdge, mdlBlank + 10);
      checkOutput($sformatf("%s writes", tag), weCount - weStart, 1);
      checkOutput($sformatf("%s reg29", tag), 32'(rf[29]), mdlBlank);
      checkOutput($sformatf("%s solved", tag), 32'(solved), 32'(mdlSolved));
      checkOutput($sformatf("%s fault", tag), 32'(fault), 0);
    end else begin
      checkOutput($sformatf("%s fault edge", tag), faultEdge, 9);
      checkOutput($sformatf("%s ready edge", tag), readyEdge, 0);
      checkOutput($sformatf("%s writes", tag), weCount - weStart, 0);
      checkOutput($sformatf("%s busy", tag), 32'(busy), 0);
    end
    checkOutput($sformatf("%s done pulses", tag), doneSeen, 0);
  endtask

  task automatic applyStimulus(input logic [1:0] dir, input bit holdValid, input int nEdges,
                               output int lat, output int illegalCount, output int doneCount,
                               output int weDelta);
    int weStart;
    int guard;
    lat          = 0;
    illegalCount = 0;
    doneCount    = 0;
    guard        = 0;
    while (cmd_ready !== 1'b1 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("cmd_ready before command", 32'(cmd_ready), 1);
    weStart   = weCount;
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    @(posedge clk); #1;
    if (holdValid) cmd_dir = dir ^ 2'b01;
    else cmd_valid = 1'b0;
    for (int k = 1; k <= nEdges; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        doneCount++;
        if (lat == 0) lat = k;
        cmd_valid = 1'b0;
      end
      if (illegal === 1'b1) begin
        illegalCount++;
        if (lat == 0) lat = k;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    weDelta   = weCount - weStart;
  endtask

  task automatic checkAfterMove(input string tag);
    for (int i = 0; i < 9; i++)
      checkOutput($sformatf("%s cell%0d", tag, i), 32'(rf[i]), mdlBoard[i]);
    checkOutput($sformatf("%s slides", tag), 32'(rf[27]), mdlSlides);
    checkOutput($sformatf("%s blank", tag), 32'(rf[29]), mdlBlank);
    checkOutput($sformatf("%s solved", tag), 32'(solved), 32'(mdlSolved));
  endtask

  task automatic doMove(input logic [1:0] dir, input bit holdValid, input string tag,
                        output int illOut);
    bit legal;
    int lat, dn, we;
    modelMove(dir, legal);
    applyStimulus(dir, holdValid, holdValid ? 30 : 16, lat, illOut, dn, we);
    checkOutput($sformatf("%s latency", tag), lat, legal ? 14 : 1);
    checkOutput($sformatf("%s done pulses", tag), dn, legal ? 1 : 0);
    checkOutput($sformatf("%s illegal pulses", tag), illOut, legal ? 0 : 1);
    checkOutput($sformatf("%s rf writes", tag), we, legal ? 4 : 0);
    checkAfterMove(tag);
  endtask

  initial begin
    int ill;
    int d;
    int s, t, tile, weStart, dn;
    bit legal;

    vecs[0]  = '{RIGHT, 1'b1, 5, 1, 1'b0};
    vecs[1]  = '{DOWN,  1'b1, 8, 2, 1'b1};
    vecs[2]  = '{RIGHT, 1'b0, 8, 2, 1'b1};
    vecs[3]  = '{DOWN,  1'b0, 8, 2, 1'b1};
    vecs[4]  = '{UP,    1'b1, 5, 3, 1'b0};
    vecs[5]  = '{LEFT,  1'b1, 4, 4, 1'b0};
    vecs[6]  = '{LEFT,  1'b1, 3, 5, 1'b0};
    vecs[7]  = '{LEFT,  1'b0, 3, 5, 1'b0};
    vecs[8]  = '{UP,    1'b1, 0, 6, 1'b0};
    vecs[9]  = '{UP,    1'b0, 0, 6, 1'b0};
    vecs[10] = '{LEFT,  1'b0, 0, 6, 1'b0};
    vecs[11] = '{RIGHT, 1'b1, 1, 7, 1'b0};
    vecs[12] = '{DOWN,  1'b1, 4, 8, 1'b0};
    vecs[13] = '{DOWN,  1'b1, 7, 9, 1'b0};
    vecs[14] = '{DOWN,  1'b0, 7, 9, 1'b0};

    $display("[TB] reset and initial scan");
    holdReset("reset");
    loadRf(boardA);
    releaseAndScan("scan A");

    $display("[TB] directed move table");
    for (int v = 0; v < 15; v++) begin
      doMove(vecs[v].dir, 1'b0, $sformatf("vec%0d", v), ill);
      checkOutput($sformatf("vec%0d table illegal", v), ill, vecs[v].expLegal ? 0 : 1);
      checkOutput($sformatf("vec%0d table blank", v), 32'(rf[29]), vecs[v].expBlank);
      checkOutput($sformatf("vec%0d table slides", v), 32'(rf[27]), vecs[v].expSlides);
      checkOutput($sformatf("vec%0d table solved", v), 32'(solved), 32'(vecs[v].expSolved));
    end

    $display("[TB] cmd_valid held while busy");
    doMove(UP, 1'b1, "held valid", ill);

    $display("[TB] randomized moves");
    for (int n = 0; n < 30; n++)
      doMove(2'($urandom_range(0, 3)), 1'b0, $sformatf("rand%0d", n), ill);

    $display("[TB] slide counter wrap");
    for (int i = 0; i < 32; i++) rfStage[i] = rf[i];
    rfStage[27] = DW'(17'h1FFFF);
    tbLoad = 1'b1;
    @(posedge clk); #1;
    tbLoad = 1'b0;
    mdlSlides = 17'h1FFFF;
    d = 0;
    while (!mdlTarget(mdlBlank, 2'(d), t)) d++;
    doMove(2'(d), 1'b0, "wrap move", ill);
    checkOutput("wrap slides zero", 32'(rf[27]), 0);

    $display("[TB] reset during CLEAR");
    d = 0;
    while (!mdlTarget(mdlBlank, 2'(d), t)) d++;
    s = mdlBlank;
    modelMove(2'(d), legal);
    t = mdlBlank;
    tile = mdlBoard[s];
    mdlBoard[t] = tile;
    mdlBlank = -1;
    weStart = weCount;
    cmd_valid = 1'b1;
    cmd_dir = 2'(d);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("midclear move write", weCount - weStart, 1);
    checkOutput("midclear cell s", 32'(rf[s]), tile);
    holdReset("midclear reset");
    checkOutput("midclear no more writes", weCount - weStart, 1);
    checkOutput("midclear cell t kept", 32'(rf[t]), tile);
    checkOutput("midclear reg29 kept", 32'(rf[29]), s);
    releaseAndScan("fault scan");
    weStart = weCount;
    dn = 0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || illegal === 1'b1) dn++;
    end
    cmd_valid = 1'b0;
    checkOutput("fault cmd_ready", 32'(cmd_ready), 0);
    checkOutput("fault busy", 32'(busy), 0);
    checkOutput("fault sticky", 32'(fault), 1);
    checkOutput("fault no response", dn, 0);
    checkOutput("fault no writes", weCount - weStart, 0);

    $display("[TB] solved board scan and move while solved");
    holdReset("reset solved");
    loadRf(boardSolved);
    releaseAndScan("scan solved");
    checkOutput("solved after scan", 32'(solved), 1);
    doMove(UP, 1'b0, "move while solved", ill);
    checkOutput("move while solved accepted", ill, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
